picorv32_mem_ctrl: RTL and testbench

Synthesizable memory slave on the picorv32 native memory bus (mem_valid/mem_ready). It replaces the behavioural bench memory that feeds the core, with:
- a word-addressed RAM with byte-strobed writes
- configurable wait states
- a backpressured MMIO output register
- a sticky bus-error flag for unmapped accesses

It sits directly downstream of picorv32 and serves both instruction fetch and data accesses, including programs that exercise the PCPI Galois coprocessor.

---
 rtl/picorv32_mem_pkg.sv | 15 +
 rtl/picorv32_mem_array.sv | 33 +++
 rtl/picorv32_mem_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_picorv32_mem_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_mem_pkg.sv
// picorv32_mem_pkg: shared FSM state codes, address region codes and the
// MMIO status bit position for the picorv32 memory slave.
package picorv32_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] RG_RAM   = 2'd0;
    localparam logic [1:0] RG_MMIO  = 2'd1;
    localparam logic [1:0] RG_UNMAP = 2'd2;

    localparam int MMIO_STAT_BIT = 0;

endpackage

// File: rtl/picorv32_mem_array.sv
// picorv32_mem_array: MEM_WORDS x 32 single-port RAM with byte-strobed
// write, synchronous read and a separate preload write port.
module picorv32_mem_array #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_wstrb,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata,
    input  logic          i_init_we,
    input  logic [AW-1:0] i_init_addr,
    input  logic [31:0]   i_init_data
);

    logic [31:0] r_mem [MEM_WORDS];

    // Read-before-write: a write cycle returns the old word.
    always_ff @(posedge clk) begin
        o_rdata <= r_mem[i_addr];
        if (i_init_we) begin
            r_mem[i_init_addr] <= i_init_data;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/picorv32_mem_ctrl.sv
// picorv32_mem_ctrl: picorv32 native-bus memory slave (RAM, MMIO, err flag).
// Define MEM_TRACE_EN to print one trace line per completed access.
module picorv32_mem_ctrl
    import picorv32_mem_pkg::*;
#(
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] MMIO_ADDR   = 32'h1000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mem_valid,
    input  logic                         mem_instr,
    input  logic [31:0]                  mem_addr,
    input  logic [31:0]                  mem_wdata,
    input  logic [3:0]                   mem_wstrb,
    output logic                         mem_ready,
    output logic [31:0]                  mem_rdata,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [31:0]                  init_data,
    output logic                         out_valid,
    output logic [31:0]                  out_data,
    input  logic                         out_ready,
    output logic                         err
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:2] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_err;

    logic        w_idle;
    logic [31:2] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [1:0]  w_region;
    logic        w_is_wr;
    logic        w_req;
    logic        w_last;
    logic        w_stall;
    logic        w_go;
    logic [3:0]  w_ram_we;
    logic [31:0] w_ram_q;
    logic        w_unused_lsb;

    // In IDLE the live bus is used so a zero-wait access completes at once.
    assign w_idle  = (r_state == ST_IDLE);
    assign w_addr  = w_idle ? mem_addr[31:2] : r_addr;
    assign w_wdata = w_idle ? mem_wdata : r_wdata;
    assign w_wstrb = w_idle ? mem_wstrb : r_wstrb;
    assign w_is_wr = |w_wstrb;

    always_comb begin
        w_region = RG_UNMAP;
        if (w_addr[31:AW+2] == '0) begin
            w_region = RG_RAM;
        end else if (w_addr == MMIO_ADDR[31:2]) begin
            w_region = RG_MMIO;
        end
    end

    assign w_req   = w_idle && mem_valid;
    assign w_last  = (r_state == ST_WAIT) && (r_cnt <= 4'd1);
    assign w_stall = (w_region == RG_MMIO) && w_is_wr
                     && r_out_valid && !out_ready;
    assign w_go    = ((w_req && (WAIT_STATES == 0)) || w_last)
                     && !w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= mem_addr[31:2];
                        r_wdata <= mem_wdata;
                        r_wstrb <= mem_wstrb;
                    end
                    if (w_go) begin
                        r_state <= ST_RESP;
                    end else if (w_req) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= (WAIT_STATES == 0) ? 4'd1
                                                      : 4'(WAIT_STATES);
                    end
                end
                ST_WAIT: begin
                    if (w_go) begin
                        r_state <= ST_RESP;
                        r_cnt   <= 4'd0;
                    end else if (!w_last) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A stalled MMIO write loads on the handshake edge, keeping out_valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_go && (w_region == RG_MMIO) && w_is_wr) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_wdata;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_go && (w_region == RG_UNMAP)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_ram_we = (w_go && !reset && (w_region == RG_RAM))
                      ? w_wstrb : 4'b0000;

    picorv32_mem_array #(
        .MEM_WORDS (MEM_WORDS)
    ) u_array (
        .clk         (clk),
        .i_addr      (w_addr[AW+1:2]),
        .i_wstrb     (w_ram_we),
        .i_wdata     (w_wdata),
        .o_rdata     (w_ram_q),
        .i_init_we   (init_we && reset),
        .i_init_addr (init_addr),
        .i_init_data (init_data)
    );

    assign mem_ready = (r_state == ST_RESP);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err       = r_err;

    always_comb begin
        mem_rdata = '0;
        if (mem_ready) begin
            unique case (w_region)
                RG_RAM:  mem_rdata = w_ram_q;
                RG_MMIO: mem_rdata[MMIO_STAT_BIT] = r_out_valid;
                default: mem_rdata = '0;
            endcase
        end
    end

    assign w_unused_lsb = ^mem_addr[1:0];

`ifdef MEM_TRACE_EN
    logic r_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= 1'b0;
        end else if (w_req) begin
            r_instr <= mem_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_ready) begin
            if (r_instr) begin
                $display("ifetch 0x%08x: 0x%08x%s", {r_addr, 2'b00},
                         mem_rdata, (w_region == RG_UNMAP) ? " ERR" : "");
            end else if (|r_wstrb) begin
                $display("write  0x%08x: 0x%08x (wstrb=%b)%s",
                         {r_addr, 2'b00}, r_wdata, r_wstrb,
                         (w_region == RG_UNMAP) ? " ERR" : "");
            end else begin
                $display("read   0x%08x: 0x%08x%s", {r_addr, 2'b00},
                         mem_rdata, (w_region == RG_UNMAP) ? " ERR" : "");
            end
        end
    end
`else
    logic w_unused_instr;
    assign w_unused_instr = mem_instr;
`endif

endmodule

// File: tb/tb_picorv32_mem_ctrl.sv
// tb_picorv32_mem_ctrl: three controllers (0, 3 and 2 wait states) driven by
// directed and random accesses, checked every cycle against a bus-level model.
module tb_picorv32_mem_ctrl;

    localparam int          N    = 3;
    localparam logic [31:0] MMIO = 32'h1000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [N];
    logic        valid     [N];
    logic        instr     [N];
    logic [31:0] addr      [N];
    logic [31:0] wdata     [N];
    logic [3:0]  wstrb     [N];
    logic        rdy       [N];
    logic [31:0] rdata     [N];
    logic        init_we   [N];
    logic [7:0]  init_addr [N];
    logic [31:0] init_data [N];
    logic        ov        [N];
    logic [31:0] od        [N];
    logic        out_ready [N];
    logic        errf      [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        picorv32_mem_ctrl #(
            .MEM_WORDS   (256),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
            .MMIO_ADDR   (MMIO)
        ) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .mem_valid (valid[g]),
            .mem_instr (instr[g]),
            .mem_addr  (addr[g]),
            .mem_wdata (wdata[g]),
            .mem_wstrb (wstrb[g]),
            .mem_ready (rdy[g]),
            .mem_rdata (rdata[g]),
            .init_we   (init_we[g]),
            .init_addr (init_addr[g]),
            .init_data (init_data[g]),
            .out_valid (ov[g]),
            .out_data  (od[g]),
            .out_ready (out_ready[g]),
            .err       (errf[g])
        );
    end

    int checks = 0;
    int fails  = 0;
    bit rnd_en = 1'b0;

    function automatic int ws(int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08x want 0x%08x", nm, act, exp);
        end
    endtask

    // Bus-level model: one outstanding request, completion after ws(k)
    // cycles, MMIO writes held until the output slot is free.
    logic [31:0] mm [N][256];
    bit          armed   [N];
    bit          busy    [N];
    bit          exp_rdy [N];
    bit          m_ov    [N];
    bit          m_err   [N];
    bit          t_mmio  [N];
    int          age     [N];
    logic [31:0] t_addr  [N];
    logic [31:0] t_wd    [N];
    logic [3:0]  t_ws    [N];
    logic [31:0] exp_rd  [N];
    logic [31:0] m_od    [N];

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            bit hs;
            bit done;
            bit is_ram;
            if (rst[k]) begin
                if (init_we[k]) mm[k][init_addr[k]] = init_data[k];
                armed[k]   = 1'b1;
                busy[k]    = 1'b0;
                exp_rdy[k] = 1'b0;
                m_ov[k]    = 1'b0;
                m_od[k]    = '0;
                m_err[k]   = 1'b0;
            end else begin
                hs   = m_ov[k] && out_ready[k];
                done = 1'b0;
                if (exp_rdy[k]) begin
                    exp_rdy[k] = 1'b0;
                end else if (!busy[k] && valid[k]) begin
                    busy[k]   = 1'b1;
                    age[k]    = 0;
                    t_addr[k] = addr[k];
                    t_wd[k]   = wdata[k];
                    t_ws[k]   = wstrb[k];
                    t_mmio[k] = (addr[k][31:2] == MMIO[31:2]);
                end else if (busy[k]) begin
                    age[k]++;
                end
                if (busy[k] && age[k] >= ws(k)) begin
                    done = !(t_mmio[k] && t_ws[k] != 0 && m_ov[k] && !hs);
                end
                if (done) begin
                    busy[k]    = 1'b0;
                    exp_rdy[k] = 1'b1;
                    is_ram     = (t_addr[k] < 32'd1024);
                    exp_rd[k]  = '0;
                    if (is_ram) begin
                        exp_rd[k] = mm[k][t_addr[k][9:2]];
                        for (int b = 0; b < 4; b++)
                            if (t_ws[k][b])
                                mm[k][t_addr[k][9:2]][8*b +: 8] = t_wd[k][8*b +: 8];
                    end else if (!t_mmio[k]) begin
                        m_err[k] = 1'b1;
                    end
                end
                if (done && t_mmio[k] && t_ws[k] != 0) begin
                    m_ov[k] = 1'b1;
                    m_od[k] = t_wd[k];
                end else if (hs) begin
                    m_ov[k] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (armed[k]) begin
                chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(exp_rdy[k]));
                if (exp_rdy[k])
                    chk($sformatf("rdata%0d", k), rdata[k],
                        t_mmio[k] ? 32'(m_ov[k]) : exp_rd[k]);
                chk($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(m_ov[k]));
                chk($sformatf("out_data%0d", k), od[k], m_od[k]);
                chk($sformatf("err%0d", k), 32'(errf[k]), 32'(m_err[k]));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (rnd_en)
                for (int k = 0; k < N; k++)
                    out_ready[k] = 1'($urandom_range(0, 1));
        end
    end

    // Called and returns at posedge+2; valid drops after the ready cycle.
    task automatic xfer(input int k, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input bit ins, output logic [31:0] rd,
                        output int lat);
        valid[k] = 1'b1;
        addr[k]  = a;
        wdata[k] = d;
        wstrb[k] = s;
        instr[k] = ins;
        lat = 0;
        rd  = '0;
        forever begin
            @(negedge clk);
            if (rdy[k]) begin
                rd = rdata[k];
                break;
            end
            lat++;
            if (lat > 60) begin
                checks++;
                fails++;
                $display("FAIL timeout%0d: got no ready want ready", k);
                break;
            end
        end
        @(posedge clk);
        #2;
        valid[k] = 1'b0;
        wstrb[k] = '0;
        instr[k] = 1'b0;
    endtask

    function automatic logic [31:0] pre(int i);
        case (i)
            0:       return 32'h7430_0093;
            1:       return 32'h0102_0304;
            2:       return 32'h1122_3344;
            3:       return 32'hCAFE_0003;
            default: return 32'hA500_0000 | 32'(i);
        endcase
    endfunction

    logic [31:0] rd;
    int          lat;
    int          nrdy;

    initial begin
        for (int k = 0; k < N; k++) begin
            rst[k]       = 1'b1;
            valid[k]     = 1'b0;
            instr[k]     = 1'b0;
            addr[k]      = '0;
            wdata[k]     = '0;
            wstrb[k]     = '0;
            init_we[k]   = 1'b0;
            init_addr[k] = '0;
            init_data[k] = '0;
            out_ready[k] = 1'b0;
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < N; k++) begin
                init_we[k]   = 1'b1;
                init_addr[k] = 8'(i);
                init_data[k] = pre(i);
            end
            @(posedge clk);
            #2;
        end
        for (int k = 0; k < N; k++) init_we[k] = 1'b0;
        @(posedge clk);
        #2;
        chk("reset_ready", 32'(rdy[0]), 32'd0);
        chk("reset_rdata", rdata[0], 32'd0);
        for (int k = 0; k < N; k++) begin
            rst[k]       = 1'b0;
            init_we[k]   = 1'b1;
            init_addr[k] = 8'd1;
            init_data[k] = 32'hBAD0_BAD0;
        end
        @(posedge clk);
        #2;
        for (int k = 0; k < N; k++) init_we[k] = 1'b0;

        xfer(0, 32'h0, 32'h0, 4'h0, 1'b1, rd, lat);
        chk("fetch_lat", 32'(lat), 32'd1);
        chk("fetch_data", rd, 32'h7430_0093);

        xfer(1, 32'h4, 32'h0, 4'h0, 1'b0, rd, lat);
        chk("ws3_lat", 32'(lat), 32'd4);
        chk("ws3_data_no_init", rd, 32'h0102_0304);

        xfer(0, 32'h8, 32'hAABB_CCDD, 4'b0100, 1'b0, rd, lat);
        chk("write_old", rd, 32'h1122_3344);
        xfer(0, 32'h8, 32'h0, 4'h0, 1'b0, rd, lat);
        chk("byte_lane", rd, 32'h11BB_3344);

        xfer(0, MMIO, 32'h41, 4'b0001, 1'b0, rd, lat);
        chk("mmio1_valid", 32'(ov[0]), 32'd1);
        chk("mmio1_data", od[0], 32'h41);
        fork
            xfer(0, MMIO, 32'h42, 4'b1111, 1'b0, rd, lat);
            begin
                repeat (3) @(posedge clk);
                #2 out_ready[0] = 1'b1;
                @(posedge clk);
                #2 out_ready[0] = 1'b0;
            end
        join
        chk("mmio_stall_lat", 32'(lat), 32'd4);
        chk("mmio2_valid", 32'(ov[0]), 32'd1);
        chk("mmio2_data", od[0], 32'h42);
        xfer(0, MMIO | 32'h3, 32'h0, 4'h0, 1'b0, rd, lat);
        chk("mmio_status1", rd, 32'd1);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #2 out_ready[0] = 1'b0;
        chk("mmio_drained", 32'(ov[0]), 32'd0);
        xfer(0, MMIO, 32'h0, 4'h0, 1'b0, rd, lat);
        chk("mmio_status0", rd, 32'd0);

        xfer(0, 32'h2000, 32'h0, 4'h0, 1'b0, rd, lat);
        chk("unmap_rdata", rd, 32'd0);
        chk("unmap_err", 32'(errf[0]), 32'd1);
        xfer(0, 32'h8, 32'h0, 4'h0, 1'b0, rd, lat);
        chk("err_sticky", 32'(errf[0]), 32'd1);

        xfer(2, 32'h8000_0000, 32'h0, 4'h0, 1'b0, rd, lat);
        xfer(2, MMIO, 32'h55, 4'b1000, 1'b0, rd, lat);
        valid[2] = 1'b1;
        addr[2]  = 32'hC;
        wdata[2] = 32'hDEAD_BEEF;
        wstrb[2] = 4'hF;
        @(posedge clk);
        #2;
        rst[2]   = 1'b1;
        valid[2] = 1'b0;
        wstrb[2] = '0;
        nrdy = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rdy[2]) nrdy++;
        end
        chk("abort_ready", 32'(nrdy), 32'd0);
        chk("abort_out_valid", 32'(ov[2]), 32'd0);
        chk("abort_out_data", od[2], 32'd0);
        chk("abort_err", 32'(errf[2]), 32'd0);
        @(posedge clk);
        #2 rst[2] = 1'b0;
        xfer(2, 32'hC, 32'h0, 4'h0, 1'b0, rd, lat);
        chk("abort_word", rd, 32'hCAFE_0003);
        chk("ws2_lat", 32'(lat), 32'd3);

        rnd_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int          k;
            int          sel;
            logic [31:0] a;
            logic [3:0]  s;
            k   = $urandom_range(0, N - 1);
            sel = $urandom_range(0, 9);
            if (sel < 7)
                a = {22'd0, 4'($urandom_range(0, 15)), 4'($urandom), 2'($urandom)};
            else if (sel < 9)
                a = MMIO | 32'($urandom_range(0, 3));
            else
                a = 32'h0000_2000 + 32'($urandom_range(0, 255) * 4);
            if (sel < 7) a[9:6] = 4'd0;
            s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            xfer(k, a, $urandom, s, 1'($urandom_range(0, 1)), rd, lat);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #2;
            end
        end
        rnd_en = 1'b0;
        @(posedge clk);
        #2;
        for (int k = 0; k < N; k++) out_ready[k] = 1'b0;

        rst[0] = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst[0] = 1'b0;
        chk("err_cleared", 32'(errf[0]), 32'd0);
        @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
